// File: rtl/bus_rr_arbiter_if.sv
// rtl/bus_rr_arbiter_if.sv - FIFO-side bus signals of the round-robin arbiter
interface bus_rr_arbiter_if #(
  parameter int pckg_sz = 16,
  parameter int drvrs   = 4
);
  logic [drvrs-1:0]         pndng;
  logic [drvrs*pckg_sz-1:0] D_pop;
  logic [drvrs-1:0]         pop;
  logic [drvrs-1:0]         push;
  logic [pckg_sz-1:0]       D_push;

  // arbiter side: reads FIFO flags and heads, drives the strobes and the bus word
  modport master (input pndng, input D_pop, output pop, output push, output D_push);
  // FIFO side
  modport slave  (output pndng, output D_pop, input pop, input push, input D_push);
endinterface

// File: rtl/bus_rr_arbiter.sv
// rtl/bus_rr_arbiter.sv - round-robin single-bus arbiter and packet router
module bus_rr_arbiter #(
  parameter int          pckg_sz   = 16,
  parameter int          drvrs     = 4,
  parameter logic [7:0]  broadcast = 8'hFF
) (
  input  logic                 clk,
  input  logic                 reset,
  bus_rr_arbiter_if.master     bus,
  output logic                 busy,
  output logic [3:0]           grant_id,
  output logic [7:0]           drop_cnt
);

  typedef enum logic [1:0] {IDLE, POP, PUSH} state_t;

  state_t               state, state_n;
  logic [3:0]           last, last_n, grant_n;
  logic [drvrs-1:0]     pop_q, pop_n, push_q, push_n;
  logic [pckg_sz-1:0]   dpush_q, dpush_n, data_q;
  logic [7:0]           dest, drop_n;
  logic                 busy_n;
  logic [3:0]           hi_win, lo_win, win;
  logic                 hi_found, lo_found;

  assign bus.pop    = pop_q;
  assign bus.push   = push_q;
  assign bus.D_push = dpush_q;

  // head word of the granted device; the FIFO holds it stable while pop is high
  always_comb begin
    data_q = '0;
    for (int j = 0; j < drvrs; j++) begin
      if (grant_id == 4'(j)) data_q = bus.D_pop[j*pckg_sz +: pckg_sz];
    end
  end

  assign dest = data_q[pckg_sz-1 -: 8];

  // round-robin pick: lowest requester above last, else lowest requester overall
  always_comb begin
    hi_found = 1'b0;
    lo_found = 1'b0;
    hi_win   = '0;
    lo_win   = '0;
    for (int j = drvrs - 1; j >= 0; j--) begin
      if (bus.pndng[j]) begin
        lo_found = 1'b1;
        lo_win   = 4'(j);
        if (j > int'(last)) begin
          hi_found = 1'b1;
          hi_win   = 4'(j);
        end
      end
    end
    win = hi_found ? hi_win : lo_win;
  end

  // next state and next registered outputs
  always_comb begin
    state_n = state;
    pop_n   = '0;
    push_n  = '0;
    dpush_n = dpush_q;
    grant_n = grant_id;
    last_n  = last;
    drop_n  = drop_cnt;
    unique case (state)
      IDLE: begin
        if (lo_found) begin
          grant_n = win;
          last_n  = win;
          for (int j = 0; j < drvrs; j++) pop_n[j] = (win == 4'(j));
          state_n = POP;
        end
      end
      POP: begin
        dpush_n = data_q;
        if (dest == broadcast) begin
          for (int j = 0; j < drvrs; j++) push_n[j] = (grant_id != 4'(j));
        end else if (int'(dest) < drvrs) begin
          for (int j = 0; j < drvrs; j++) push_n[j] = (dest == 8'(j));
        end else if (drop_cnt != 8'hFF) begin
          drop_n = drop_cnt + 8'd1;
        end
        state_n = PUSH;
      end
      PUSH: state_n = IDLE;
      default: state_n = IDLE;
    endcase
    busy_n = (state_n != IDLE);
  end

  // state and output registers; reset abandons any transfer in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      pop_q    <= '0;
      push_q   <= '0;
      dpush_q  <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      drop_cnt <= '0;
      last     <= 4'(drvrs - 1);
    end else begin
      state    <= state_n;
      pop_q    <= pop_n;
      push_q   <= push_n;
      dpush_q  <= dpush_n;
      busy     <= busy_n;
      grant_id <= grant_n;
      drop_cnt <= drop_n;
      last     <= last_n;
    end
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// tb/tb_bus_rr_arbiter.sv - self-checking bench for bus_rr_arbiter
module tb_bus_rr_arbiter;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       busy;
  logic [3:0] grant_id;
  logic [7:0] drop_cnt;

  int checks = 0;
  int errors = 0;
  int m_last;
  int exp_drop;

  bus_rr_arbiter_if #(.pckg_sz(16), .drvrs(N)) bus ();

  bus_rr_arbiter #(.pckg_sz(16), .drvrs(N), .broadcast(8'hFF)) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .busy(busy), .grant_id(grant_id), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  pend;
    logic [15:0] data;
    int          grant;
    logic [3:0]  epush;
    logic        edrop;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int mdl_grant(input logic [3:0] p, input int last);
    int best = -1;
    int bd = 1000;
    for (int i = 0; i < N; i++) begin
      if (p[i]) begin
        int d = (i - last - 1 + 2 * N) % N;
        if (d < bd) begin bd = d; best = i; end
      end
    end
    return best;
  endfunction

  function automatic logic [3:0] mdl_mask(input logic [15:0] pkt, input int src);
    int dst = int'(pkt[15:8]);
    if (dst == 255) return 4'hF & ~(4'd1 << src);
    if (dst < N) return 4'd1 << dst;
    return 4'd0;
  endfunction

  function automatic logic mdl_drop(input logic [15:0] pkt);
    return (pkt[15:8] != 8'hFF) && (int'(pkt[15:8]) >= N);
  endfunction

  // called at a negedge with the DUT in IDLE; exact latency is checked cycle by cycle
  task automatic run_xfer(input logic [3:0] pend, input logic [63:0] dp, input int eg,
                          input logic [3:0] epush, input logic [15:0] edata, input logic rnd);
    bus.pndng = pend;
    bus.D_pop = dp;
    @(negedge clk);
    if (pend == 4'd0) begin
      chk("idle_pop", 32'(bus.pop), 0);
      chk("idle_busy", 32'(busy), 0);
      return;
    end
    chk("pop_strobe", 32'(bus.pop), 32'(4'd1 << eg));
    chk("grant_id", 32'(grant_id), 32'(eg));
    chk("busy_pop", 32'(busy), 1);
    chk("push_in_pop", 32'(bus.push), 0);
    if (rnd) bus.pndng = 4'($urandom);
    @(negedge clk);
    if (rnd) bus.D_pop = {$urandom, $urandom};
    chk("push_mask", 32'(bus.push), 32'(epush));
    chk("d_push", 32'(bus.D_push), 32'(edata));
    chk("pop_in_push", 32'(bus.pop), 0);
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    @(negedge clk);
    chk("push_end", 32'(bus.push), 0);
    chk("busy_end", 32'(busy), 0);
    chk("d_push_hold", 32'(bus.D_push), 32'(edata));
    bus.pndng = 4'd0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.pndng = 4'd0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    m_last = N - 1;
    exp_drop = 0;
  endtask

  initial begin
    logic [63:0] dp;
    logic [15:0] pkt;
    int g;

    bus.pndng = 4'd0;
    bus.D_pop = '0;
    tbl[0] = '{4'b0001, 16'h0205, 0, 4'b0100, 1'b0};
    tbl[1] = '{4'b0100, 16'hFF33, 2, 4'b1011, 1'b0};
    tbl[2] = '{4'b0010, 16'h0711, 1, 4'b0000, 1'b1};
    tbl[3] = '{4'b1000, 16'h0300, 3, 4'b1000, 1'b0};
    tbl[4] = '{4'b1111, 16'h0101, 0, 4'b0010, 1'b0};
    tbl[5] = '{4'b1111, 16'hFF00, 1, 4'b1101, 1'b0};
    tbl[6] = '{4'b1001, 16'h0200, 3, 4'b0100, 1'b0};
    tbl[7] = '{4'b0000, 16'h0000, 0, 4'b0000, 1'b0};
    tbl[8] = '{4'b0011, 16'h0800, 0, 4'b0000, 1'b1};

    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_pop", 32'(bus.pop), 0);
    chk("rst_push", 32'(bus.push), 0);
    chk("rst_dpush", 32'(bus.D_push), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_grant", 32'(grant_id), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    reset = 1'b0;
    m_last = N - 1;
    exp_drop = 0;

    // directed vectors: each device slice carries data ^ index so the routed slice is visible
    for (int v = 0; v < 9; v++) begin
      for (int i = 0; i < N; i++) dp[i*16 +: 16] = tbl[v].data ^ 16'(i);
      if (tbl[v].edrop && exp_drop < 255) exp_drop++;
      run_xfer(tbl[v].pend, dp, tbl[v].grant, tbl[v].epush, tbl[v].data ^ 16'(tbl[v].grant), 1'b0);
      if (tbl[v].pend != 4'd0) m_last = tbl[v].grant;
    end

    // random traffic against the reference model, flags and data scrambled mid-transfer
    for (int r = 0; r < 200; r++) begin
      logic [3:0] p;
      p = 4'($urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        int sel = int'($urandom_range(0, 5));
        pkt[7:0] = 8'($urandom);
        pkt[15:8] = (sel < 4) ? 8'(sel) : (sel == 4) ? 8'hFF : 8'($urandom_range(4, 254));
        dp[i*16 +: 16] = pkt;
      end
      g = mdl_grant(p, m_last);
      if (g < 0) begin
        run_xfer(p, dp, 0, 4'd0, 16'd0, 1'b1);
      end else begin
        pkt = dp[g*16 +: 16];
        if (mdl_drop(pkt) && exp_drop < 255) exp_drop++;
        run_xfer(p, dp, g, mdl_mask(pkt, g), pkt, 1'b1);
        m_last = g;
      end
    end

    // reset during POP: transfer abandoned, outputs cleared, priority back to device 0
    bus.pndng = 4'b0100;
    bus.D_pop = {16'h0033, 16'h0022, 16'h0011, 16'h0000};
    @(negedge clk);
    chk("rp_pop", 32'(bus.pop), 32'b0100);
    reset = 1'b1;
    bus.pndng = 4'd0;
    @(negedge clk);
    chk("rp_pop0", 32'(bus.pop), 0);
    chk("rp_push0", 32'(bus.push), 0);
    chk("rp_dpush0", 32'(bus.D_push), 0);
    chk("rp_busy0", 32'(busy), 0);
    chk("rp_grant0", 32'(grant_id), 0);
    chk("rp_drop0", 32'(drop_cnt), 0);
    reset = 1'b0;
    m_last = N - 1;
    exp_drop = 0;
    @(negedge clk);
    chk("rp_nopush", 32'(bus.push), 0);

    // all devices continuously pending: grants 0,1,2,3,0, one packet per 3 cycles
    for (int i = 0; i < N; i++) dp[i*16 +: 16] = {8'((i + 1) % N), 8'hA0 + 8'(i)};
    for (int k = 0; k < 5; k++) begin
      g = k % N;
      run_xfer(4'hF, dp, g, 4'd1 << ((g + 1) % N), dp[g*16 +: 16], 1'b0);
    end

    // drop counter saturation
    do_reset();
    dp = {16'h0000, 16'h0000, 16'h0711, 16'h0000};
    for (int k = 0; k < 300; k++) begin
      if (exp_drop < 255) exp_drop++;
      run_xfer(4'b0010, dp, 1, 4'd0, 16'h0711, 1'b0);
    end
    chk("drop_sat", 32'(drop_cnt), 255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
